counter_display_driver: RTL and testbench
=========================================

# counter_display_driver

Downstream consumer of the 4-bit synchronous binary counter. Converts the counter value 0..15 into two decimal digits and drives a 2-digit time-multiplexed 7-segment display. It uses a blanking gap between digits, suppresses a leading tens zero, and takes a frame-coherent snapshot so digits never tear. It also emits a one-cycle `wrap` pulse whenever the counter returns to zero.

## Interface
- `SCAN_DIV`, 50000, clock cycles per digit slot (≥ 2).
- `BLANK_CYC`, 4, cycles at the start of each slot with all anodes off (1 ≤ BLANK_CYC < SCAN_DIV).
- `ACTIVE_LOW`, 1, when 1 the `seg` and `an` outputs are inverted (common-anode board); when 0 they are active-high.
- `clk`  input  1  system clock, all state changes on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `counter`  input  4  binary count from the upstream counter, synchronous to `clk`.
- `seg`  output  7  segment drive, bit0 = a … bit6 = g.
- `an`  output  2  digit enable, bit0 = ones digit, bit1 = tens digit.
- `wrap`  output  1  one-cycle pulse when the counter value returns to 0.

## Operation
- Input stage: `cnt_q` registers `counter` every cycle.
- Conversion of `cnt_q`:
  - If `cnt_q` ≥ 10: tens = 1, ones = `cnt_q` − 10.
  - Otherwise: tens = 0, ones = `cnt_q`.
- Snapshot registers `tens_s` (1 bit) and `ones_s` (4 bits) load the converted value only on the SHOW_T→BLANK_O transition. They hold for the whole frame.
- Scan FSM uses states BLANK_O, SHOW_O, BLANK_T, SHOW_T and a slot prescaler `pc` (0..SCAN_DIV−1, advancing by 1 per cycle).
  - BLANK_O→SHOW_O when `pc` == BLANK_CYC−1.
  - SHOW_O→BLANK_T when `pc` == SCAN_DIV−1; `pc` returns to 0.
  - BLANK_T→SHOW_T when `pc` == BLANK_CYC−1.
  - SHOW_T→BLANK_O when `pc` == SCAN_DIV−1; `pc` returns to 0 and the snapshot is loaded.
- Output decode (values below are active-high; inverted when ACTIVE_LOW = 1):
  - BLANK_x: `an` = 00, `seg` = 0.
  - SHOW_O: `an` = 01, `seg` = font(`ones_s`).
  - SHOW_T: `an` = 10 and `seg` = font(1) when `tens_s` = 1. When `tens_s` = 0 (leading-zero suppression), `an` = 00 and `seg` = 0.
- Font (hex, active-high): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Codes above 9 cannot occur; decode them to 0.
- Wrap detect: `wrap` is registered as (`counter` == 0 && `cnt_q` != 0).
  - It goes high for exactly one cycle after the first edge that samples 0 following a nonzero value.
  - A counter held at 0 produces no further pulses.

## Timing
- Reset (asynchronous, takes effect without a clock edge):
  - `cnt_q`, `tens_s`, `ones_s`, `pc` = 0; FSM = BLANK_O.
  - `wrap` = 0; `an`/`seg` at their inactive level (00/0 active-high, 11/7F when ACTIVE_LOW).
- `seg`, `an` and `wrap` are registered outputs. `seg`/`an` reflect the FSM state and `pc` of the previous cycle.
- Frame length is 2×SCAN_DIV cycles. Each digit is lit SCAN_DIV−BLANK_CYC cycles per frame.
- Input-to-display latency is 1 cycle into `cnt_q`, then until the next frame boundary, then 1 output-register cycle. The worst case is 2×SCAN_DIV + 2 cycles.
- Counter changes mid-frame never alter the currently displayed digits.
- Reset mid-frame: outputs go inactive immediately. After release the FSM restarts at BLANK_O with snapshot 0, so the first frame shows ones "0" with tens blank.
- Counter value changing in the same cycle as the frame boundary: the snapshot takes `cnt_q`, i.e. the value sampled one edge earlier.

## Test plan
All scenarios use SCAN_DIV=4, BLANK_CYC=1, ACTIVE_LOW=0, giving an 8-cycle frame.
- Assert `reset` asynchronously between edges -> `an`=00, `seg`=00, `wrap`=0 immediately; FSM in BLANK_O after release.
- `counter`=7 held from reset release -> frame 1 shows "0" on ones (`an`=01, `seg`=3F) with tens blank. From frame 2: SHOW_O gives `an`=01, `seg`=07; SHOW_T gives `an`=00 for 3 cycles; BLANK slots give `an`=00 for 1 cycle each.
- `counter`=13 held -> after snapshot, SHOW_O gives `an`=01, `seg`=4F; SHOW_T gives `an`=10, `seg`=06.
- `counter` steps 15→0 and holds 0 -> `wrap`=1 for exactly one cycle, on the first edge after the change; then 0 thereafter. Repeat with `counter` held at 0 from reset -> `wrap` never asserts.
- `counter` changes 3→9 during SHOW_O -> `seg` stays 4F for the remainder of the frame. The next frame shows 6F.
- Reset pulsed during SHOW_T with `counter`=12 -> outputs inactive at once. After release, the first frame shows `seg`=3F, `an`=01; the following frame shows "12" (ones 5B, tens 06).

Source files
------------

// File: rtl/counter_display_driver.sv
// rtl/counter_display_driver.sv - 0..15 counter to 2-digit multiplexed 7-segment display driver
// Frame-coherent snapshot, blanking gap, leading-zero suppression and wrap pulse.
module counter_display_driver #(
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] counter,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       wrap
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PC_LAST    = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);
  localparam logic [6:0]    SEG_OFF    = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0]    AN_OFF     = ACTIVE_LOW ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {BLANK_O, SHOW_O, BLANK_T, SHOW_T} state_t;

  state_t        state;
  state_t        state_nx;
  logic [PW-1:0] pc;
  logic [3:0]    cnt_q;
  logic [3:0]    ones_s;
  logic          tens_s;
  logic [3:0]    ones_c;
  logic          tens_c;
  logic          snap_load;
  logic [6:0]    seg_nx;
  logic [1:0]    an_nx;

  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'd0:    font = 7'h3F;
      4'd1:    font = 7'h06;
      4'd2:    font = 7'h5B;
      4'd3:    font = 7'h4F;
      4'd4:    font = 7'h66;
      4'd5:    font = 7'h6D;
      4'd6:    font = 7'h7D;
      4'd7:    font = 7'h07;
      4'd8:    font = 7'h7F;
      4'd9:    font = 7'h6F;
      default: font = 7'h00;
    endcase
  endfunction

  always_comb begin
    tens_c = 1'b0;
    ones_c = cnt_q;
    if (cnt_q >= 4'd10) begin
      tens_c = 1'b1;
      ones_c = cnt_q - 4'd10;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BLANK_O;
    else       state <= state_nx;
  end

  // Active-high decode here; polarity is applied at the output register.
  always_comb begin
    state_nx  = state;
    snap_load = 1'b0;
    an_nx     = 2'b00;
    seg_nx    = 7'h00;
    case (state)
      BLANK_O: if (pc == BLANK_LAST) state_nx = SHOW_O;
      SHOW_O: begin
        an_nx  = 2'b01;
        seg_nx = font(ones_s);
        if (pc == PC_LAST) state_nx = BLANK_T;
      end
      BLANK_T: if (pc == BLANK_LAST) state_nx = SHOW_T;
      SHOW_T: begin
        if (tens_s) begin
          an_nx  = 2'b10;
          seg_nx = font(4'd1);
        end
        if (pc == PC_LAST) begin
          state_nx  = BLANK_O;
          snap_load = 1'b1;
        end
      end
      default: state_nx = BLANK_O;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 4'd0;
      pc     <= '0;
      tens_s <= 1'b0;
      ones_s <= 4'd0;
      wrap   <= 1'b0;
      seg    <= SEG_OFF;
      an     <= AN_OFF;
    end else begin
      cnt_q <= counter;
      pc    <= (pc == PC_LAST) ? '0 : pc + 1'b1;
      if (snap_load) begin
        tens_s <= tens_c;
        ones_s <= ones_c;
      end
      wrap <= (counter == 4'd0) && (cnt_q != 4'd0);
      seg  <= ACTIVE_LOW ? ~seg_nx : seg_nx;
      an   <= ACTIVE_LOW ? ~an_nx  : an_nx;
    end
  end

endmodule

// File: tb/tb_counter_display_driver.sv
// tb/tb_counter_display_driver.sv - scoreboard bench for counter_display_driver
// Small geometry: SCAN_DIV=4, BLANK_CYC=1, active-high, 8-cycle frames.
module tb_counter_display_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] counter = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       wrap;

  typedef struct packed {
    logic [1:0] an;
    logic [6:0] seg;
    logic       wrap;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   idx = 0;

  counter_display_driver #(
    .SCAN_DIV(4),
    .BLANK_CYC(1),
    .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .counter(counter),
    .seg(seg),
    .an(an),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        idx++;
        if ({an, seg, wrap} !== e) begin
          bad++;
          $display("FAIL scan#%0d: got an=%b seg=%h wrap=%b, want an=%b seg=%h wrap=%b",
                   idx, an, seg, wrap, e.an, e.seg, e.wrap);
        end
      end
    end
  end

  task automatic chk_rst(input string name, input logic [7:0] got);
    total++;
    if (got !== 8'h00) begin
      bad++;
      $display("FAIL %s: got %h, want 00", name, got);
    end
  endtask

  task automatic do_reset(input logic [3:0] v);
    @(negedge clk);
    #1;
    reset   = 1'b1;
    counter = v;
    #1;
    chk_rst("reset_an", {6'd0, an});
    chk_rst("reset_seg", {1'b0, seg});
    chk_rst("reset_wrap", {7'd0, wrap});
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // One frame (or its first ncyc cycles): slot 0 blank, 1-3 ones, 4 blank, 5-7 tens.
  task automatic frame(input logic [3:0] va, input logic [3:0] vb, input int sw,
                       input logic [6:0] os, input logic ten, input logic w0,
                       input int ncyc = 8);
    exp_t e;
    for (int p = 0; p < ncyc; p++) begin
      counter = (p < sw) ? va : vb;
      @(posedge clk);
      #1;
      e.wrap = (p == 0) ? w0 : 1'b0;
      if (p >= 1 && p <= 3) begin
        e.an = 2'b01; e.seg = os;
      end else if (p >= 5 && ten) begin
        e.an = 2'b10; e.seg = 7'h06;
      end else begin
        e.an = 2'b00; e.seg = 7'h00;
      end
      q.push_back(e);
    end
  endtask

  initial begin
    // counter=7 from release: first frame shows the reset snapshot 0
    do_reset(4'd7);
    frame(4'd7, 4'd7, 8, 7'h3F, 1'b0, 1'b0);
    frame(4'd7, 4'd7, 8, 7'h07, 1'b0, 1'b0);
    // 13: one frame of latency before the new snapshot
    frame(4'd13, 4'd13, 8, 7'h07, 1'b0, 1'b0);
    frame(4'd13, 4'd13, 8, 7'h4F, 1'b1, 1'b0);
    // 15 -> 0: single wrap pulse, then held at 0
    frame(4'd15, 4'd15, 8, 7'h4F, 1'b1, 1'b0);
    frame(4'd0, 4'd0, 8, 7'h6D, 1'b1, 1'b1);
    frame(4'd0, 4'd0, 8, 7'h3F, 1'b0, 1'b0);
    // counter held at 0 from reset: no wrap
    do_reset(4'd0);
    frame(4'd0, 4'd0, 8, 7'h3F, 1'b0, 1'b0);
    frame(4'd0, 4'd0, 8, 7'h3F, 1'b0, 1'b0);
    // 3 -> 9 mid SHOW_O keeps 3 on screen; change on boundary cycle is not captured
    frame(4'd3, 4'd3, 8, 7'h3F, 1'b0, 1'b0);
    frame(4'd3, 4'd9, 2, 7'h4F, 1'b0, 1'b0);
    frame(4'd9, 4'd2, 7, 7'h6F, 1'b0, 1'b0);
    frame(4'd2, 4'd2, 8, 7'h6F, 1'b0, 1'b0);
    // 12, then reset during SHOW_T
    frame(4'd12, 4'd12, 8, 7'h5B, 1'b0, 1'b0);
    frame(4'd12, 4'd12, 8, 7'h5B, 1'b1, 1'b0, 7);
    do_reset(4'd12);
    frame(4'd12, 4'd12, 8, 7'h3F, 1'b0, 1'b0);
    frame(4'd12, 4'd12, 8, 7'h5B, 1'b1, 1'b0);
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
